// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Brief    : Shared op codes, FSM states and sign-fix helpers for muldiv_seq.
//  Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [3:0] {
        MFHI  = 4'b0000,
        MTHI  = 4'b0001,
        MFLO  = 4'b0010,
        MTLO  = 4'b0011,
        MULT  = 4'b1000,
        MULTU = 4'b1001,
        DIV   = 4'b1010,
        DIVU  = 4'b1011
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } muldiv_state_e;

    localparam int unsigned MAX_W = 64;

    // Helpers work on a 64-bit carrier; callers zero-extend in and cast back to
    // their own width, so any operand width up to MAX_W is handled.
    function automatic logic [MAX_W-1:0] width_mask(input int unsigned n);
        return (n >= MAX_W) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    function automatic logic [MAX_W-1:0] neg_n(input logic [MAX_W-1:0] v, input int unsigned n);
        return (~v + 64'd1) & width_mask(n);
    endfunction

    function automatic logic [MAX_W-1:0] abs_n(input logic [MAX_W-1:0] v, input int unsigned n);
        logic [MAX_W-1:0] sh;
        sh = v >> (n - 1);
        return sh[0] ? neg_n(v, n) : (v & width_mask(n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_seq_if
//  Brief    : Command / result bundle between the CPU and the mul/div unit.
//  Revision : 1.0 - initial release
// ============================================================================
interface muldiv_seq_if
    import muldiv_pkg::*;
#(
    parameter int N = 8
);
    logic         start;
    logic [3:0]   F;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] y;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         busy;
    logic         done;
    logic         dz;

    modport master (
        output start, F, a, b,
        input  y, hi, lo, busy, done, dz
    );

    modport slave (
        input  start, F, a, b,
        output y, hi, lo, busy, done, dz
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_seq
//  Brief    : Iterative radix-2 MIPS-style MULT/DIV unit with HI/LO registers.
//             Operand width N must lie in 2..32.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int N = 8
) (
    input  wire logic   clk,
    input  wire logic   rst,
    muldiv_seq_if.slave bus
);

    localparam int W2 = 2 * N;
    localparam int CW = $clog2(N + 1);

    muldiv_state_e   r_state;
    logic [CW-1:0]   r_cnt;
    logic [W2-1:0]   r_acc;
    logic [N-1:0]    r_opnd;
    logic            r_is_div;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_div_zero;
    logic [N-1:0]    r_hi;
    logic [N-1:0]    r_lo;
    logic            r_done;
    logic            r_dz;

    muldiv_op_e      w_op;
    logic            w_signed;
    logic            w_sign_a;
    logic            w_sign_b;
    logic [N-1:0]    w_mag_a;
    logic [N-1:0]    w_mag_b;
    logic [N:0]      w_sum;
    logic [W2-1:0]   w_mul_next;
    logic [W2:0]     w_shift;
    logic [N:0]      w_trial;
    logic [W2-1:0]   w_div_next;
    logic [W2-1:0]   w_prod_fix;
    logic [N-1:0]    w_quo;
    logic [N-1:0]    w_rem;
    logic [N-1:0]    w_y;

    assign w_op     = muldiv_op_e'(bus.F);
    assign w_signed = (w_op == MULT) || (w_op == DIV);
    assign w_sign_a = w_signed & bus.a[N-1];
    assign w_sign_b = w_signed & bus.b[N-1];
    assign w_mag_a  = w_signed ? N'(abs_n(64'(bus.a), N)) : bus.a;
    assign w_mag_b  = w_signed ? N'(abs_n(64'(bus.b), N)) : bus.b;

    // Shift-add step: accumulator is {partial product, remaining multiplier}.
    assign w_sum      = {1'b0, r_acc[W2-1:N]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_sum, r_acc[N-1:1]};

    // Restoring step: accumulator is {partial remainder, dividend/quotient}.
    assign w_shift    = {r_acc, 1'b0};
    assign w_trial    = w_shift[W2:N] - {1'b0, r_opnd};
    assign w_div_next = w_trial[N] ? w_shift[W2-1:0]
                                   : {w_trial[N-1:0], w_shift[N-1:1], 1'b1};

    assign w_prod_fix = r_neg_q ? W2'(neg_n(64'(r_acc), W2)) : r_acc;
    assign w_quo      = r_neg_q ? N'(neg_n(64'(r_acc[N-1:0]), N)) : r_acc[N-1:0];
    assign w_rem      = r_neg_r ? N'(neg_n(64'(r_acc[W2-1:N]), N)) : r_acc[W2-1:N];

    always_comb begin
        w_y = '0;
        case (w_op)
            MFHI:    w_y = r_hi;
            MFLO:    w_y = r_lo;
            default: w_y = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_dz       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_dz <= 1'b0;
                        case (w_op)
                            MTHI: r_hi <= bus.a;
                            MTLO: r_lo <= bus.a;
                            MULT, MULTU: begin
                                r_is_div   <= 1'b0;
                                r_div_zero <= 1'b0;
                                r_neg_q    <= w_sign_a ^ w_sign_b;
                                r_neg_r    <= 1'b0;
                                r_acc      <= {{N{1'b0}}, w_mag_b};
                                r_opnd     <= w_mag_a;
                                r_cnt      <= CW'(N);
                                r_state    <= RUN;
                            end
                            DIV, DIVU: begin
                                r_is_div <= 1'b1;
                                r_neg_q  <= w_sign_a ^ w_sign_b;
                                r_neg_r  <= w_sign_a;
                                r_acc    <= {{N{1'b0}}, w_mag_a};
                                r_opnd   <= w_mag_b;
                                r_cnt    <= CW'(N);
                                if (bus.b == '0) begin
                                    r_div_zero <= 1'b1;
                                    r_state    <= FIN;
                                end else begin
                                    r_div_zero <= 1'b0;
                                    r_state    <= RUN;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                    if (r_div_zero) begin
                        r_dz <= 1'b1;
                    end else if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod_fix[W2-1:N];
                        r_lo <= w_prod_fix[N-1:0];
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.y    = w_y;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = (r_state != IDLE);
    assign bus.done = r_done;
    assign bus.dz   = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_seq
//  Brief    : Directed self-checking bench for muldiv_seq with N=8.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   lat;
    int   bcnt;

    muldiv_seq_if #(.N(8)) bus ();

    muldiv_seq #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a command for exactly one rising edge (the accept edge E0).
    task automatic cmd(input logic [3:0] f, input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        bus.start = 1'b1;
        bus.F     = f;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // lat = rising edges after E0 until done is seen; -1 on timeout.
    task automatic wait_done(output int l, output int bc);
        l  = -1;
        bc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                l = i - 1;
                break;
            end
            if (bus.busy) bc++;
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.F     = 4'b0000;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("rst_hi",   32'(bus.hi),   32'h0);
        check("rst_lo",   32'(bus.lo),   32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_dz",   32'(bus.dz),   32'h0);
        rst = 1'b0;

        // MULTU 200*100 = 20000 = 0x4E20
        cmd(MULTU, 8'd200, 8'd100);
        wait_done(lat, bcnt);
        check("multu_lat",  32'(lat),      32'd9);
        check("multu_busy", 32'(bcnt),     32'd9);
        check("multu_bz",   32'(bus.busy), 32'h0);
        check("multu_hi",   32'(bus.hi),   32'h4E);
        check("multu_lo",   32'(bus.lo),   32'h20);
        @(negedge clk);
        check("done_pulse", 32'(bus.done), 32'h0);

        // MULT -3*5 = -15
        cmd(MULT, 8'hFD, 8'h05);
        wait_done(lat, bcnt);
        check("mult_hi", 32'(bus.hi), 32'hFF);
        check("mult_lo", 32'(bus.lo), 32'hF1);

        // DIV -7/2 = -3 rem -1
        cmd(DIV, 8'hF9, 8'h02);
        wait_done(lat, bcnt);
        check("div_lat", 32'(lat),    32'd9);
        check("div_lo",  32'(bus.lo), 32'hFD);
        check("div_hi",  32'(bus.hi), 32'hFF);
        check("div_dz",  32'(bus.dz), 32'h0);

        // DIV MIN/-1 wraps
        cmd(DIV, 8'h80, 8'hFF);
        wait_done(lat, bcnt);
        check("ovf_lo", 32'(bus.lo), 32'h80);
        check("ovf_hi", 32'(bus.hi), 32'h00);

        // DIVU 255/16 = 15 rem 15
        cmd(DIVU, 8'hFF, 8'h10);
        wait_done(lat, bcnt);
        check("divu_lo", 32'(bus.lo), 32'h0F);
        check("divu_hi", 32'(bus.hi), 32'h0F);

        // Moves take effect at the accept edge with no busy/done
        cmd(MTHI, 8'h12, 8'h00);
        check("mthi_busy", 32'(bus.busy), 32'h0);
        cmd(MTLO, 8'h34, 8'h00);
        @(negedge clk);
        check("mt_hi",   32'(bus.hi),   32'h12);
        check("mt_lo",   32'(bus.lo),   32'h34);
        check("mt_done", 32'(bus.done), 32'h0);

        // Undefined code is a no-op
        cmd(4'b0101, 8'h55, 8'h55);
        @(negedge clk);
        check("undef_busy", 32'(bus.busy), 32'h0);
        check("undef_hi",   32'(bus.hi),   32'h12);

        // Divide by zero
        cmd(DIVU, 8'd7, 8'd0);
        wait_done(lat, bcnt);
        check("dz_lat", 32'(lat),    32'd1);
        check("dz_flag", 32'(bus.dz), 32'h1);
        check("dz_hi",  32'(bus.hi), 32'h12);
        check("dz_lo",  32'(bus.lo), 32'h34);
        @(negedge clk);
        check("dz_sticky", 32'(bus.dz), 32'h1);
        cmd(MFHI, 8'h00, 8'h00);
        @(negedge clk);
        check("dz_clear", 32'(bus.dz), 32'h0);
        check("y_mfhi",   32'(bus.y),  32'h12);
        bus.F = MFLO;
        #1 check("y_mflo", 32'(bus.y), 32'h34);
        bus.F = MTHI;
        #1 check("y_other", 32'(bus.y), 32'h00);

        // Start while busy is ignored: 0xF0*0xF0 = 0xE100
        cmd(MULTU, 8'hF0, 8'hF0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.F     = MTHI;
        bus.a     = 8'hAA;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat, bcnt);
        check("busy_ign_ok", 32'(lat >= 0), 32'h1);
        check("busy_ign_hi", 32'(bus.hi),   32'hE1);
        check("busy_ign_lo", 32'(bus.lo),   32'h00);

        // Reset mid-run abandons the op
        cmd(MULTU, 8'h0F, 8'h0F);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_hi",   32'(bus.hi),   32'h0);
        check("midrst_lo",   32'(bus.lo),   32'h0);
        check("midrst_busy", 32'(bus.busy), 32'h0);
        check("midrst_done", 32'(bus.done), 32'h0);
        cmd(MULTU, 8'h0F, 8'h0F);
        wait_done(lat, bcnt);
        check("post_lat", 32'(lat),    32'd9);
        check("post_hi",  32'(bus.hi), 32'h00);
        check("post_lo",  32'(bus.lo), 32'hE1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
